// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register: carries GPR, HI/LO and LLbit writes to write-back,
// with stall/bubble/flush control and a retired-instruction counter.
module mem_wb_pipe #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int STALL_W = 6,
  parameter int MEM_IDX = 4,
  parameter int WB_IDX  = 5,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               mem_valid,
  input  logic [ADDR_W-1:0]  mem_wd,
  input  logic               mem_wreg,
  input  logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_whilo,
  input  logic [DATA_W-1:0]  mem_hi,
  input  logic [DATA_W-1:0]  mem_lo,
  input  logic               mem_llbit_we,
  input  logic               mem_llbit_value,
  output logic               wb_valid,
  output logic [ADDR_W-1:0]  wb_wd,
  output logic               wb_wreg,
  output logic [DATA_W-1:0]  wb_wdata,
  output logic               wb_whilo,
  output logic [DATA_W-1:0]  wb_hi,
  output logic [DATA_W-1:0]  wb_lo,
  output logic               wb_llbit_we,
  output logic               wb_llbit_value,
  output logic [CNT_W-1:0]   retire_cnt
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] wd_q, wd_d;
  logic              wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              whilo_q, whilo_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              llbit_we_q, llbit_we_d;
  logic              llbit_value_q, llbit_value_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic advance;
  logic bubble;
  logic stall_unused;

  // WB stalled with MEM running is illegal; it falls through to advance.
  assign advance      = !stall[MEM_IDX];
  assign bubble       = stall[MEM_IDX] && !stall[WB_IDX];
  assign stall_unused = ^stall;

  always_comb begin
    valid_d       = valid_q;
    wd_d          = wd_q;
    wreg_d        = wreg_q;
    wdata_d       = wdata_q;
    whilo_d       = whilo_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    llbit_we_d    = llbit_we_q;
    llbit_value_d = llbit_value_q;
    cnt_d         = cnt_q;
    if (flush || bubble) begin
      valid_d       = 1'b0;
      wd_d          = '0;
      wreg_d        = 1'b0;
      wdata_d       = '0;
      whilo_d       = 1'b0;
      hi_d          = '0;
      lo_d          = '0;
      llbit_we_d    = 1'b0;
      llbit_value_d = 1'b0;
    end else if (advance) begin
      valid_d       = mem_valid;
      wd_d          = mem_wd;
      wreg_d        = mem_wreg;
      wdata_d       = mem_wdata;
      whilo_d       = mem_whilo;
      hi_d          = mem_hi;
      lo_d          = mem_lo;
      llbit_we_d    = mem_llbit_we;
      llbit_value_d = mem_llbit_value;
      if (mem_valid) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= 1'b0;
      wd_q          <= '0;
      wreg_q        <= 1'b0;
      wdata_q       <= '0;
      whilo_q       <= 1'b0;
      hi_q          <= '0;
      lo_q          <= '0;
      llbit_we_q    <= 1'b0;
      llbit_value_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      valid_q       <= valid_d;
      wd_q          <= wd_d;
      wreg_q        <= wreg_d;
      wdata_q       <= wdata_d;
      whilo_q       <= whilo_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      llbit_we_q    <= llbit_we_d;
      llbit_value_q <= llbit_value_d;
      cnt_q         <= cnt_d;
    end
  end

  assign wb_valid       = valid_q;
  assign wb_wd          = wd_q;
  assign wb_wreg        = wreg_q;
  assign wb_wdata       = wdata_q;
  assign wb_whilo       = whilo_q;
  assign wb_hi          = hi_q;
  assign wb_lo          = lo_q;
  assign wb_llbit_we    = llbit_we_q;
  assign wb_llbit_value = llbit_value_q;
  assign retire_cnt     = cnt_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe: a default-width instance plus a CNT_W=4
// instance sharing the same stimulus, checked against a stage model every cycle.
module tb_mem_wb_pipe;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        mem_valid;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_llbit_we;
  logic        mem_llbit_value;

  logic        wb_valid, wb_wreg, wb_whilo, wb_llbit_we, wb_llbit_value;
  logic [4:0]  wb_wd;
  logic [31:0] wb_wdata, wb_hi, wb_lo, retire_cnt;

  logic        s_valid, s_wreg, s_whilo, s_llbit_we, s_llbit_value;
  logic [4:0]  s_wd;
  logic [31:0] s_wdata, s_hi, s_lo;
  logic [3:0]  s_retire_cnt;

  int vectors = 0;
  int miscompares = 0;

  mem_wb_pipe dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .mem_wdata(mem_wdata), .mem_whilo(mem_whilo), .mem_hi(mem_hi),
    .mem_lo(mem_lo), .mem_llbit_we(mem_llbit_we), .mem_llbit_value(mem_llbit_value),
    .wb_valid(wb_valid), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_llbit_we(wb_llbit_we),
    .wb_llbit_value(wb_llbit_value), .retire_cnt(retire_cnt)
  );

  mem_wb_pipe #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .mem_wdata(mem_wdata), .mem_whilo(mem_whilo), .mem_hi(mem_hi),
    .mem_lo(mem_lo), .mem_llbit_we(mem_llbit_we), .mem_llbit_value(mem_llbit_value),
    .wb_valid(s_valid), .wb_wd(s_wd), .wb_wreg(s_wreg), .wb_wdata(s_wdata),
    .wb_whilo(s_whilo), .wb_hi(s_hi), .wb_lo(s_lo), .wb_llbit_we(s_llbit_we),
    .wb_llbit_value(s_llbit_value), .retire_cnt(s_retire_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: what WB must hold, plus a plain count of retired instructions.
  typedef struct {
    logic        valid;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        llwe;
    logic        llval;
  } stage_t;

  stage_t      exp_stage;
  stage_t      empty_stage;
  longint      retired;
  logic        model_ready = 1'b0;

  always @(posedge clk) begin
    empty_stage = '{valid: 1'b0, wd: 5'd0, wreg: 1'b0, wdata: 32'd0, whilo: 1'b0,
                    hi: 32'd0, lo: 32'd0, llwe: 1'b0, llval: 1'b0};
    if (rst) begin
      exp_stage = empty_stage;
      retired   = 0;
    end else if (flush || (stall[4] && !stall[5])) begin
      exp_stage = empty_stage;
    end else if (!stall[4]) begin
      exp_stage = '{valid: mem_valid, wd: mem_wd, wreg: mem_wreg, wdata: mem_wdata,
                    whilo: mem_whilo, hi: mem_hi, lo: mem_lo, llwe: mem_llbit_we,
                    llval: mem_llbit_value};
      if (mem_valid) retired = retired + 1;
    end
    model_ready = 1'b1;
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (model_ready) begin
      check_output("wb_valid", 64'(wb_valid), 64'(exp_stage.valid));
      check_output("wb_wd", 64'(wb_wd), 64'(exp_stage.wd));
      check_output("wb_wreg", 64'(wb_wreg), 64'(exp_stage.wreg));
      check_output("wb_wdata", 64'(wb_wdata), 64'(exp_stage.wdata));
      check_output("wb_whilo", 64'(wb_whilo), 64'(exp_stage.whilo));
      check_output("wb_hi", 64'(wb_hi), 64'(exp_stage.hi));
      check_output("wb_lo", 64'(wb_lo), 64'(exp_stage.lo));
      check_output("wb_llbit_we", 64'(wb_llbit_we), 64'(exp_stage.llwe));
      check_output("wb_llbit_value", 64'(wb_llbit_value), 64'(exp_stage.llval));
      check_output("retire_cnt", 64'(retire_cnt), 64'(retired % 64'h1_0000_0000));
      check_output("small_wdata", 64'(s_wdata), 64'(exp_stage.wdata));
      check_output("small_retire_cnt", 64'(s_retire_cnt), 64'(retired % 16));
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic valid, input logic [4:0] wd, input logic wreg,
                                input logic [31:0] wdata, input logic whilo,
                                input logic [31:0] hi, input logic [31:0] lo,
                                input logic llwe, input logic llval);
    mem_valid       = valid;
    mem_wd          = wd;
    mem_wreg        = wreg;
    mem_wdata       = wdata;
    mem_whilo       = whilo;
    mem_hi          = hi;
    mem_lo          = lo;
    mem_llbit_we    = llwe;
    mem_llbit_value = llval;
  endtask

  task automatic randomize_inputs();
    apply_stimulus(1'($urandom), 5'($urandom), 1'($urandom), $urandom, 1'($urandom),
                   $urandom, $urandom, 1'($urandom), 1'($urandom));
  endtask

  initial begin
    rst   = 1'b1;
    stall = 6'b000000;
    flush = 1'b0;
    randomize_inputs();

    // Reset with random inputs
    tick(1);
    randomize_inputs();
    tick(1);
    check_output("lit_reset_valid", 64'(wb_valid), 64'd0);
    check_output("lit_reset_wdata", 64'(wb_wdata), 64'd0);
    check_output("lit_reset_cnt", 64'(retire_cnt), 64'd0);

    rst = 1'b0;
    apply_stimulus(1'b1, 5'd3, 1'b1, 32'hDEADBEEF, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick(1);
    check_output("lit_first_wd", 64'(wb_wd), 64'd3);
    check_output("lit_first_wreg", 64'(wb_wreg), 64'd1);
    check_output("lit_first_wdata", 64'(wb_wdata), 64'hDEADBEEF);
    check_output("lit_first_cnt", 64'(retire_cnt), 64'd1);

    // Hold for three cycles while inputs change
    apply_stimulus(1'b1, 5'd7, 1'b1, 32'h12345678, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick(1);
    stall = 6'b110000;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 5'(i + 9), 1'b1, 32'hA0 + 32'(i), 1'b1, 32'd1, 32'd2, 1'b1, 1'b1);
      tick(1);
    end
    check_output("lit_hold_wdata", 64'(wb_wdata), 64'h12345678);
    check_output("lit_hold_cnt", 64'(retire_cnt), 64'd2);
    stall = 6'b000000;
    apply_stimulus(1'b1, 5'd8, 1'b1, 32'hCAFEF00D, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick(1);
    check_output("lit_release_wdata", 64'(wb_wdata), 64'hCAFEF00D);
    check_output("lit_release_cnt", 64'(retire_cnt), 64'd3);

    // Bubble
    stall = 6'b011111;
    apply_stimulus(1'b1, 5'd4, 1'b1, 32'h11111111, 1'b1, 32'd5, 32'd6, 1'b0, 1'b0);
    tick(1);
    check_output("lit_bubble_wreg", 64'(wb_wreg), 64'd0);
    check_output("lit_bubble_whilo", 64'(wb_whilo), 64'd0);
    check_output("lit_bubble_valid", 64'(wb_valid), 64'd0);
    check_output("lit_bubble_cnt", 64'(retire_cnt), 64'd3);

    // Flush overrides hold; then reset overrides too and clears the counter
    stall = 6'b000000;
    apply_stimulus(1'b1, 5'd2, 1'b1, 32'h22222222, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
    tick(1);
    stall = 6'b110000;
    flush = 1'b1;
    tick(1);
    check_output("lit_flush_llwe", 64'(wb_llbit_we), 64'd0);
    check_output("lit_flush_wdata", 64'(wb_wdata), 64'd0);
    check_output("lit_flush_cnt", 64'(retire_cnt), 64'd4);
    rst = 1'b1;
    tick(1);
    check_output("lit_rst_flush_cnt", 64'(retire_cnt), 64'd0);
    rst   = 1'b0;
    flush = 1'b0;
    stall = 6'b000000;

    // HI/LO and LLbit pass-through
    apply_stimulus(1'b1, 5'd0, 1'b0, 32'd0, 1'b1, 32'hAAAA0000, 32'h0000BBBB, 1'b1, 1'b1);
    tick(1);
    check_output("lit_hi", 64'(wb_hi), 64'hAAAA0000);
    check_output("lit_lo", 64'(wb_lo), 64'h0000BBBB);
    check_output("lit_llval", 64'(wb_llbit_value), 64'd1);

    // Illegal WB-only stall and unrelated stall bits both advance
    stall = 6'b100000;
    apply_stimulus(1'b1, 5'd1, 1'b1, 32'h55, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick(1);
    check_output("lit_illegal_wdata", 64'(wb_wdata), 64'h55);
    stall = 6'b001111;
    apply_stimulus(1'b1, 5'd1, 1'b1, 32'h66, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick(1);
    check_output("lit_other_bits_cnt", 64'(retire_cnt), 64'd3);

    // Counter wrap on the 4-bit instance, invalid advances interleaved
    stall = 6'b000000;
    rst   = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      apply_stimulus(1'b1, 5'(i), 1'b1, 32'(i), 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      tick(1);
      apply_stimulus(1'b0, 5'd0, 1'b0, 32'(i), 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      tick(1);
    end
    check_output("lit_wrap_max", 64'(s_retire_cnt), 64'hF);
    apply_stimulus(1'b1, 5'd1, 1'b1, 32'h77, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick(1);
    check_output("lit_wrap_zero", 64'(s_retire_cnt), 64'h0);
    check_output("lit_wrap_wide", 64'(retire_cnt), 64'd16);

    // Mixed traffic checked by the model only
    for (int i = 0; i < 60; i++) begin
      randomize_inputs();
      if (!mem_valid) mem_wreg = 1'b0;
      case ($urandom_range(0, 9))
        6:       stall = 6'b110000;
        7:       stall = 6'b010000;
        8:       stall = 6'b100000;
        9:       stall = 6'b001111;
        default: stall = 6'b000000;
      endcase
      flush = ($urandom_range(0, 15) == 0);
      tick(1);
    end

    tick(1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
- Parametrised MEM→WB pipeline register for the next-generation core.
- Carries the following from the memory-access stage to write-back:
  - GPR write (address, enable, data)
  - HI/LO write
  - LLbit write
  - instruction-valid flag
- Adds pipeline stall/bubble control, exception flush and a retired-instruction counter.
- Outputs drive the Regfile, the HI/LO register unit and the LLbit register directly.

Parameters:
- DATA_W, 32, width of GPR/HI/LO data.
- ADDR_W, 5, width of GPR address.
- STALL_W, 6, width of the global stall vector.
- MEM_IDX, 4, stall-vector bit index of the MEM stage.
- WB_IDX, 5, stall-vector bit index of the WB stage.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- stall  in  STALL_W  global stall vector from the control unit; bit i=1 holds stage i
- flush  in  1  exception flush; clears the stage register
- mem_valid  in  1  MEM stage holds a real (non-bubble) instruction
- mem_wd  in  ADDR_W  GPR destination address
- mem_wreg  in  1  GPR write enable
- mem_wdata  in  DATA_W  GPR write data
- mem_whilo  in  1  HI/LO write enable
- mem_hi  in  DATA_W  HI write data
- mem_lo  in  DATA_W  LO write data
- mem_llbit_we  in  1  LLbit write enable
- mem_llbit_value  in  1  LLbit write value
- wb_valid  out  1  WB holds a real instruction
- wb_wd  out  ADDR_W  registered mem_wd
- wb_wreg  out  1  registered mem_wreg
- wb_wdata  out  DATA_W  registered mem_wdata
- wb_whilo  out  1  registered mem_whilo
- wb_hi  out  DATA_W  registered mem_hi
- wb_lo  out  DATA_W  registered mem_lo
- wb_llbit_we  out  1  registered mem_llbit_we
- wb_llbit_value  out  1  registered mem_llbit_value
- retire_cnt  out  CNT_W  count of instructions retired through WB

Behaviour:
- Reset: reset rst, synchronous, active-high; clock clk. While rst=1 at a rising edge, every output goes to 0:
  - all enables 0 (write-disable)
  - wb_wd = 0 (NOP register address)
  - data outputs 0
  - wb_valid = 0
  - retire_cnt = 0
- Latency: one cycle, MEM inputs → wb_* outputs. No combinational input→output path.
- Per-edge action, priority order (first match wins):
  1. rst=1 → full reset as above.
  2. flush=1 → stage cleared to bubble (all wb_* = 0, including wb_valid). retire_cnt unchanged.
  3. stall[MEM_IDX]=1 and stall[WB_IDX]=0 → bubble inserted (same values as flush). retire_cnt unchanged.
  4. stall[MEM_IDX]=0 → advance: all wb_* load their mem_* inputs, wb_valid loads mem_valid.
  5. Otherwise (both MEM and WB stalled) → hold: all wb_* keep their values.
- Bubble/flush contents: the write enables (wb_wreg, wb_whilo, wb_llbit_we) must be 0, so no architectural state changes. Data fields are also zeroed for deterministic traces.
- retire_cnt:
  - Increments by 1 on an advance edge with mem_valid=1.
  - No increment on hold, bubble, flush, or advance with mem_valid=0.
  - Wraps modulo 2^CNT_W: all-ones → 0, no saturation, no flag.
- Enable gating: enables are passed through verbatim; the block never gates wreg by valid. The MEM stage guarantees mem_wreg=0 whenever mem_valid=0.
- stall bits other than MEM_IDX/WB_IDX are ignored.
- The combination stall[WB_IDX]=1, stall[MEM_IDX]=0 is illegal from the control unit. If it occurs, the block treats it as advance (rule 4).
- Reset or flush arriving mid-stall overrides the hold in the same edge.

Test Plan:
- Reset: hold rst=1 for 2 cycles with random inputs → all wb_* = 0, retire_cnt = 0. Release, drive mem_valid=1, mem_wd=5'd3, mem_wreg=1, mem_wdata=32'hDEADBEEF → next edge wb_wd=3, wb_wreg=1, wb_wdata=DEADBEEF, retire_cnt=1.
- Hold: after loading wdata=32'h12345678, set stall=6'b110000 for 3 cycles while inputs change → outputs stay 12345678, retire_cnt unchanged. Release → new inputs load, retire_cnt +1.
- Bubble: stall=6'b011111 with mem_wreg=1, mem_whilo=1 → next edge wb_wreg=0, wb_whilo=0, wb_valid=0, retire_cnt unchanged.
- Flush priority: flush=1 together with stall=6'b110000 and mem_llbit_we=1 → wb_llbit_we=0, all outputs 0. Same edge with rst=1 also clears retire_cnt.
- HI/LO and LLbit pass-through: mem_whilo=1, mem_hi=32'hAAAA0000, mem_lo=32'h0000BBBB, mem_llbit_we=1, mem_llbit_value=1 → all appear on wb_* one cycle later.
- Counter wrap (CNT_W=4): 16 consecutive valid advances → retire_cnt reaches 4'hF then 0. Advances with mem_valid=0 interleaved → no increment.
